// File: rtl/mem_port_arbiter_if.sv
// Bundle of the instruction port, data port and memory-side signals shared
// between the arbiter and whatever drives it (core + memory).
interface mem_port_arbiter_if;
  // instruction-fetch port
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  // load/store port
  logic        d_req;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  // single shared memory port
  logic        mem_enable;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  // arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_data_out,
    output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
    output mem_enable, mem_wr, mem_addr, mem_data_in
  );

  // requester / memory side
  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_data_out,
    input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
    input  mem_enable, mem_wr, mem_addr, mem_data_in
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single-ported memory.
// Each transaction runs IDLE -> ACCESS -> RESP; the data port normally wins
// conflicts, but after STARVE_LIMIT consecutive lost conflicts the
// instruction port is given the next one.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // control state
  logic        owner_d;      // 1: data port owns the current transaction
  logic [3:0]  starve_cnt;

  // latched transaction (data path, not reset)
  logic [31:0] lat_addr;
  logic        lat_wr;
  logic [31:0] lat_wdata;

  // per-port result registers
  logic [31:0] i_rdata_r;
  logic        i_err_r;
  logic [31:0] d_rdata_r;
  logic        d_err_r;

  logic        grant_i;
  logic        grant_d;
  logic        aligned;

  // Saturating increment of the starvation counter.
  function automatic logic [3:0] starve_inc(input logic [3:0] cnt);
    if (cnt >= LIMIT) return LIMIT;
    return cnt + 4'd1;
  endfunction

  assign aligned = (lat_addr[1:0] == 2'b00);

  // Arbitration: only meaningful in IDLE; data wins unless instruction starved.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (bus.i_req && bus.d_req) begin
        if (starve_cnt == LIMIT) grant_i = 1'b1;
        else                     grant_d = 1'b1;
      end else if (bus.i_req) begin
        grant_i = 1'b1;
      end else if (bus.d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: ACCESS and RESP each last exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_i || grant_d) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Owner and starvation bookkeeping, updated on every grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_d    <= 1'b0;
      starve_cnt <= 4'd0;
    end else if (grant_i) begin
      owner_d    <= 1'b0;
      starve_cnt <= 4'd0;
    end else if (grant_d) begin
      owner_d    <= 1'b1;
      if (bus.i_req) starve_cnt <= starve_inc(starve_cnt);
    end
  end

  // Capture the winner's request; the instruction port never writes.
  always_ff @(posedge clk) begin
    if (grant_i) begin
      lat_addr  <= bus.i_addr;
      lat_wr    <= 1'b0;
      lat_wdata <= 32'd0;
    end else if (grant_d) begin
      lat_addr  <= bus.d_addr;
      lat_wr    <= bus.d_wr;
      lat_wdata <= bus.d_wdata;
    end
  end

  // Result registers: loaded at the end of ACCESS, held until the port's next completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rdata_r <= 32'd0;
      i_err_r   <= 1'b0;
      d_rdata_r <= 32'd0;
      d_err_r   <= 1'b0;
    end else if (state == ACCESS) begin
      if (owner_d) begin
        d_err_r <= !aligned;
        if (!aligned)     d_rdata_r <= 32'd0;
        else if (!lat_wr) d_rdata_r <= bus.mem_data_out;
      end else begin
        i_err_r <= !aligned;
        if (!aligned) i_rdata_r <= 32'd0;
        else          i_rdata_r <= bus.mem_data_out;
      end
    end
  end

  // Outputs: memory driven only in an aligned ACCESS; acks only in RESP.
  // Because state resets asynchronously, mem_enable drops the moment rst rises.
  always_comb begin
    bus.mem_enable  = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_addr    = 32'd0;
    bus.mem_data_in = 32'd0;
    bus.i_ack       = 1'b0;
    bus.d_ack       = 1'b0;
    if (state == ACCESS && aligned) begin
      bus.mem_enable  = 1'b1;
      bus.mem_wr      = lat_wr;
      bus.mem_addr    = lat_addr;
      bus.mem_data_in = lat_wdata;
    end
    if (state == RESP) begin
      bus.i_ack = !owner_d;
      bus.d_ack = owner_d;
    end
    bus.i_rdata = i_rdata_r;
    bus.i_err   = i_err_r;
    bus.d_rdata = d_rdata_r;
    bus.d_err   = d_err_r;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter with a word-addressed
// memory model and a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // memory the DUT talks to
  logic [31:0] mem [0:255];
  assign bus.mem_data_out = mem[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (bus.mem_enable && bus.mem_wr) mem[bus.mem_addr[9:2]] <= bus.mem_data_in;
  end

  // reference model state
  logic [31:0] ref_mem [0:255];
  int          starve_m;
  logic [31:0] exp_i_rdata, exp_d_rdata;
  logic        exp_i_err, exp_d_err;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {22'd0, 10'($urandom)};
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  // Called at a falling edge while the DUT is idle, with requests already driven.
  // Checks one full transaction and leaves the bench at the next idle falling edge.
  task automatic run_txn(input bit drop, output bit obs_gi);
    bit          gi, wr, al;
    logic [31:0] a, wd;
    gi = bus.i_req && (!bus.d_req || starve_m == LIMIT);
    a  = gi ? bus.i_addr : bus.d_addr;
    wr = gi ? 1'b0 : bus.d_wr;
    wd = gi ? 32'd0 : bus.d_wdata;
    al = (a[1:0] == 2'b00);
    if (gi)             starve_m = 0;
    else if (bus.i_req) starve_m = (starve_m + 1 > LIMIT) ? LIMIT : starve_m + 1;
    if (!al) begin
      if (gi) begin exp_i_rdata = 32'd0; exp_i_err = 1'b1; end
      else    begin exp_d_rdata = 32'd0; exp_d_err = 1'b1; end
    end else if (gi) begin
      exp_i_rdata = ref_mem[a[9:2]]; exp_i_err = 1'b0;
    end else begin
      exp_d_err = 1'b0;
      if (wr) ref_mem[a[9:2]] = wd;
      else    exp_d_rdata = ref_mem[a[9:2]];
    end
    @(negedge clk);  // memory access cycle
    check("acc_mem_enable", 32'(bus.mem_enable), 32'(al));
    check("acc_mem_wr", 32'(bus.mem_wr), 32'(al & wr));
    check("acc_mem_addr", bus.mem_addr, al ? a : 32'd0);
    check("acc_mem_data_in", bus.mem_data_in, al ? wd : 32'd0);
    check("acc_acks", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
    @(negedge clk);  // response cycle
    check("rsp_i_ack", 32'(bus.i_ack), 32'(gi));
    check("rsp_d_ack", 32'(bus.d_ack), 32'(!gi));
    check("rsp_mem_enable", 32'(bus.mem_enable), 32'd0);
    check("rsp_i_rdata", bus.i_rdata, exp_i_rdata);
    check("rsp_i_err", 32'(bus.i_err), 32'(exp_i_err));
    check("rsp_d_rdata", bus.d_rdata, exp_d_rdata);
    check("rsp_d_err", 32'(bus.d_err), 32'(exp_d_err));
    obs_gi = bus.i_ack;
    if (drop) begin
      if (gi) bus.i_req = 1'b0;
      else    bus.d_req = 1'b0;
    end
    @(negedge clk);  // back to idle
    check("idle_acks", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
    check("idle_mem_enable", 32'(bus.mem_enable), 32'd0);
    check("idle_mem_addr", bus.mem_addr, 32'd0);
  endtask

  bit g;
  bit exp_order [0:9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  logic [31:0] old80;

  initial begin
    for (int k = 0; k < 256; k++) begin
      mem[k]     <= 32'hA5A5_0000 ^ 32'(k * 32'h0101_0101);
      ref_mem[k]  = 32'hA5A5_0000 ^ 32'(k * 32'h0101_0101);
    end
    mem[8'h40]     <= 32'hDEAD_BEEF;
    ref_mem[8'h40]  = 32'hDEAD_BEEF;
    starve_m = 0;
    exp_i_rdata = 32'd0; exp_d_rdata = 32'd0; exp_i_err = 1'b0; exp_d_err = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = 32'd0;
    bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = 32'd0; bus.d_wdata = 32'd0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_acks_errs", {28'd0, bus.i_ack, bus.d_ack, bus.i_err, bus.d_err}, 32'd0);
    check("rst_i_rdata", bus.i_rdata, 32'd0);
    check("rst_d_rdata", bus.d_rdata, 32'd0);
    check("rst_mem_ctl", {30'd0, bus.mem_enable, bus.mem_wr}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_data_in", bus.mem_data_in, 32'd0);

    // load of 0xDEADBEEF, arbitrated on the first edge after reset release
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 32'h100;
    rst = 1'b0;
    run_txn(1'b1, g);

    // store then fetch of the same word
    bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'h1234_5678;
    run_txn(1'b1, g);
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    run_txn(1'b1, g);
    check("fetch_rdata", bus.i_rdata, 32'h1234_5678);

    // continuous conflict: grant order D,D,D,D,I repeated
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 32'h100;
    for (int k = 0; k < 10; k++) begin
      run_txn(1'b0, g);
      check("conflict_order", 32'(g), 32'(exp_order[k]));
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;

    // misaligned store: no memory access, error response
    bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 32'h102; bus.d_wdata = 32'hFFFF_FFFF;
    run_txn(1'b1, g);
    check("misaligned_err", 32'(bus.d_err), 32'd1);
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 32'h100;
    run_txn(1'b1, g);
    check("misaligned_mem_intact", bus.d_rdata, 32'hDEAD_BEEF);

    // reset asserted mid-store to 0x80
    old80 = ref_mem[8'h20];
    bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 32'h80; bus.d_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    check("mid_rst_access", 32'(bus.mem_enable), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_mem_enable", 32'(bus.mem_enable), 32'd0);
    check("mid_rst_mem_addr", bus.mem_addr, 32'd0);
    check("mid_rst_rdata", bus.i_rdata | bus.d_rdata, 32'd0);
    @(negedge clk);
    check("mid_rst_no_ack", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
    rst = 1'b0; bus.d_req = 1'b0;
    starve_m = 0;
    exp_i_rdata = 32'd0; exp_d_rdata = 32'd0; exp_i_err = 1'b0; exp_d_err = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_idle", {30'd0, bus.d_ack, bus.mem_enable}, 32'd0);
    end
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 32'h80;
    run_txn(1'b1, g);
    check("mid_rst_mem_kept", bus.d_rdata, old80);

    // randomized traffic; a pending loser keeps its inputs stable
    for (int k = 0; k < 60; k++) begin
      if (!bus.i_req && $urandom_range(0, 2) != 0) begin
        bus.i_req = 1'b1; bus.i_addr = rand_addr();
      end
      if (!bus.d_req && $urandom_range(0, 2) != 0) begin
        bus.d_req = 1'b1; bus.d_wr = 1'($urandom); bus.d_addr = rand_addr(); bus.d_wdata = $urandom;
      end
      if (!bus.i_req && !bus.d_req) begin
        bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = rand_addr();
      end
      run_txn(1'b1, g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
